// File: rtl/rx_packet_builder_pkg.sv
// Shared constants, state encoding and header helpers for the RX inband packet builder.
package rx_packet_builder_pkg;

   localparam int PKT_WORDS     = 256;
   localparam int HDR_WORDS     = 4;
   localparam int PAYLOAD_WORDS = PKT_WORDS - HDR_WORDS;
   localparam int PAYLOAD_BYTES = PAYLOAD_WORDS * 2;

   // Channel index width covers up to four data channels.
   localparam int CHAN_IDX_W = 2;

   // Reserved for the control channel; never produced by this block.
   localparam logic [4:0] CTRL_CHAN = 5'h1F;

   localparam int W0_OVERRUN   = 31;
   localparam int W0_UNDERRUN  = 30;
   localparam int W0_SOB       = 29;
   localparam int W0_EOB       = 28;
   localparam int W0_RSSI_LSB  = 22;
   localparam int W0_TAG_LSB   = 18;
   localparam int W0_CHAN_LSB  = 9;
   localparam int W0_BYTES_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR0    = 3'd1,
      ST_HDR1    = 3'd2,
      ST_HDR2    = 3'd3,
      ST_HDR3    = 3'd4,
      ST_PAYLOAD = 3'd5
   } state_t;

   function automatic logic [5:0] sat_rssi(input logic [31:0] r);
      return (|r[31:6]) ? 6'h3F : r[5:0];
   endfunction

   function automatic logic [31:0] build_w0(input logic ovr,
                                            input logic [5:0] rssi6,
                                            input logic [CHAN_IDX_W-1:0] chan);
      logic [31:0] w;
      w                         = '0;
      w[W0_OVERRUN]             = ovr;
      w[W0_UNDERRUN]            = 1'b0;
      w[W0_SOB]                 = 1'b0;
      w[W0_EOB]                 = 1'b0;
      w[W0_RSSI_LSB +: 6]       = rssi6;
      w[W0_TAG_LSB +: 4]        = 4'h0;
      w[W0_CHAN_LSB +: 5]       = 5'(chan);
      w[W0_BYTES_LSB +: 9]      = 9'(PAYLOAD_BYTES);
      return w;
   endfunction

endpackage

// File: rtl/rx_packet_builder_if.sv
// USB-side RX FIFO write port: word, write strobe and space indication.
interface rx_packet_builder_if;
   logic [15:0] out_data;
   logic        out_wr;
   logic        out_have_space;

   modport master (output out_data, output out_wr, input out_have_space);
   modport slave  (input out_data, input out_wr, output out_have_space);
endinterface

// File: rtl/rx_rr_arbiter.sv
// Round-robin channel picker: first eligible channel at or above the pointer, wrapping.
module rx_rr_arbiter
   import rx_packet_builder_pkg::*;
#(
   parameter int NUM_CHAN = 2
) (
   input  logic                  rxclk,
   input  logic                  reset,
   input  logic [NUM_CHAN-1:0]   eligible,
   input  logic                  advance,
   input  logic [CHAN_IDX_W-1:0] adv_chan,
   output logic [CHAN_IDX_W-1:0] grant,
   output logic                  valid
);

   localparam int IW = CHAN_IDX_W + 1;

   logic [CHAN_IDX_W-1:0] rr_ptr;
   logic [IW-1:0]         idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         idx = {1'b0, rr_ptr} + IW'(i);
         if (idx >= IW'(NUM_CHAN)) idx = idx - IW'(NUM_CHAN);
         for (int j = 0; j < NUM_CHAN; j++) begin
            if (!valid && (idx == IW'(j)) && eligible[j]) begin
               grant = CHAN_IDX_W'(j);
               valid = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge rxclk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (adv_chan == CHAN_IDX_W'(NUM_CHAN - 1)) ? '0 : adv_chan + CHAN_IDX_W'(1);
      end
   end

endmodule

// File: rtl/rx_packet_builder.sv
// Drains per-channel RX FIFOs into 256-word inband packets (4 header + 252 samples).
//
// state      | meaning
// IDLE       | arbitrate; latch channel, timestamp and rssi on grant
// HDR0       | emit W0[15:0]
// HDR1       | emit W0[31:16]; clear this channel's sticky overrun
// HDR2       | emit timestamp[15:0]
// HDR3       | emit timestamp[31:16]; load payload down-counter
// PAYLOAD    | read cur_chan FIFO for 252 cycles, then back to IDLE
module rx_packet_builder
   import rx_packet_builder_pkg::*;
#(
   parameter int NUM_CHAN = 2
) (
   input  logic                     rxclk,
   input  logic                     reset,
   input  logic [NUM_CHAN-1:0]      rx_enable,
   input  logic [9*NUM_CHAN-1:0]    chan_usedw,
   input  logic [16*NUM_CHAN-1:0]   chan_fifodata,
   output logic [NUM_CHAN-1:0]      chan_rdreq,
   input  logic [NUM_CHAN-1:0]      chan_overrun,
   input  logic [32*NUM_CHAN-1:0]   rssi,
   input  logic [31:0]              timestamp,
   rx_packet_builder_if.master      usb,
   output logic [15:0]              pkt_count,
   output logic                     busy
);

   state_t                state, state_nxt;
   logic [NUM_CHAN-1:0]   eligible, ovr_flag;
   logic [CHAN_IDX_W-1:0] grant, cur_chan;
   logic                  grant_valid, advance;
   logic [31:0]           ts_q, grant_rssi, w0;
   logic [5:0]            rssi6_q;
   logic [7:0]            pay_cnt;
   logic [15:0]           cur_data, word_nxt;
   logic                  cur_ovr, wr_nxt;

   always_comb begin
      eligible   = '0;
      grant_rssi = '0;
      cur_data   = '0;
      cur_ovr    = 1'b0;
      for (int k = 0; k < NUM_CHAN; k++) begin
         eligible[k] = rx_enable[k] && (chan_usedw[9*k +: 9] >= 9'(PAYLOAD_WORDS))
                       && usb.out_have_space;
         if (grant == CHAN_IDX_W'(k)) grant_rssi = rssi[32*k +: 32];
         if (cur_chan == CHAN_IDX_W'(k)) begin
            cur_data = chan_fifodata[16*k +: 16];
            cur_ovr  = ovr_flag[k];
         end
      end
   end

   rx_rr_arbiter #(.NUM_CHAN(NUM_CHAN)) u_arb (
      .rxclk    (rxclk),
      .reset    (reset),
      .eligible (eligible),
      .advance  (advance),
      .adv_chan (cur_chan),
      .grant    (grant),
      .valid    (grant_valid)
   );

   assign w0 = build_w0(cur_ovr, rssi6_q, cur_chan);

   always_ff @(posedge rxclk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      advance    = 1'b0;
      chan_rdreq = '0;
      word_nxt   = '0;
      wr_nxt     = 1'b0;
      case (state)
         ST_IDLE: if (grant_valid) state_nxt = ST_HDR0;
         ST_HDR0: begin
            state_nxt = ST_HDR1;
            wr_nxt    = 1'b1;
            word_nxt  = w0[15:0];
         end
         ST_HDR1: begin
            state_nxt = ST_HDR2;
            wr_nxt    = 1'b1;
            word_nxt  = w0[31:16];
         end
         ST_HDR2: begin
            state_nxt = ST_HDR3;
            wr_nxt    = 1'b1;
            word_nxt  = ts_q[15:0];
         end
         ST_HDR3: begin
            state_nxt = ST_PAYLOAD;
            wr_nxt    = 1'b1;
            word_nxt  = ts_q[31:16];
         end
         ST_PAYLOAD: begin
            wr_nxt   = 1'b1;
            word_nxt = cur_data;
            for (int k = 0; k < NUM_CHAN; k++)
               chan_rdreq[k] = (cur_chan == CHAN_IDX_W'(k));
            if (pay_cnt == 8'd0) begin
               state_nxt = ST_IDLE;
               advance   = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge rxclk or negedge reset) begin
      if (!reset) begin
         usb.out_data <= '0;
         usb.out_wr   <= 1'b0;
         cur_chan     <= '0;
         ts_q         <= '0;
         rssi6_q      <= '0;
         pay_cnt      <= '0;
         pkt_count    <= '0;
         ovr_flag     <= '0;
      end else begin
         usb.out_data <= word_nxt;
         usb.out_wr   <= wr_nxt;
         if (state == ST_IDLE && grant_valid) begin
            cur_chan <= grant;
            ts_q     <= timestamp;
            rssi6_q  <= sat_rssi(grant_rssi);
         end
         if (state == ST_HDR3)         pay_cnt <= 8'(PAYLOAD_WORDS - 1);
         else if (state == ST_PAYLOAD) pay_cnt <= pay_cnt - 8'd1;
         if (advance) pkt_count <= pkt_count + 16'd1;
         // A new overrun pulse outranks the clear at HDR1.
         for (int k = 0; k < NUM_CHAN; k++) begin
            if (chan_overrun[k])
               ovr_flag[k] <= 1'b1;
            else if (state == ST_HDR1 && cur_chan == CHAN_IDX_W'(k))
               ovr_flag[k] <= 1'b0;
         end
      end
   end

   // Covers the final payload beat, which leaves the register after the FSM is back in IDLE.
   assign busy = (state != ST_IDLE) || usb.out_wr;

endmodule

// File: tb/tb_rx_packet_builder.sv
// Directed-sequence bench with random FIFO contents, checked against a packet-level model.
module tb_rx_packet_builder;

   logic        rxclk = 1'b0;
   logic        reset;
   logic [1:0]  rx_enable;
   logic [17:0] chan_usedw;
   logic [31:0] chan_fifodata;
   logic [1:0]  chan_rdreq;
   logic [1:0]  chan_overrun;
   logic [63:0] rssi;
   logic [31:0] timestamp;
   logic [15:0] pkt_count;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [15:0] q0 [$];
   logic [15:0] q1 [$];

   int seq_ch    [7] = '{1, 0, 1, 0, 1, 0, 1};
   int seq_ovr   [7] = '{0, 0, 1, 0, 1, 0, 0};
   int seq_pbeat [7] = '{-1, 100, 0, -1, -1, -1, -1};

   rx_packet_builder_if usb ();

   rx_packet_builder #(.NUM_CHAN(2)) dut (
      .rxclk         (rxclk),
      .reset         (reset),
      .rx_enable     (rx_enable),
      .chan_usedw    (chan_usedw),
      .chan_fifodata (chan_fifodata),
      .chan_rdreq    (chan_rdreq),
      .chan_overrun  (chan_overrun),
      .rssi          (rssi),
      .timestamp     (timestamp),
      .usb           (usb),
      .pkt_count     (pkt_count),
      .busy          (busy)
   );

   always #5 rxclk = ~rxclk;

   // Show-ahead FIFO model: pop on read strobe, present the new head at the falling edge.
   always @(posedge rxclk) begin
      if (chan_rdreq[0] === 1'b1 && q0.size() > 0) q0.delete(0);
      if (chan_rdreq[1] === 1'b1 && q1.size() > 0) q1.delete(0);
   end

   function automatic logic [8:0] sat9(input int n);
      return (n > 511) ? 9'd511 : 9'(n);
   endfunction

   always @(negedge rxclk) begin
      chan_fifodata[15:0]  = (q0.size() > 0) ? q0[0] : 16'h0000;
      chan_fifodata[31:16] = (q1.size() > 0) ? q1[0] : 16'h0000;
      chan_usedw[8:0]      = sat9(q0.size());
      chan_usedw[17:9]     = sat9(q1.size());
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int ch, input int n);
      for (int i = 0; i < n; i++) begin
         if (ch == 0) q0.push_back(16'($urandom));
         else         q1.push_back(16'($urandom));
      end
   endtask

   task automatic idle_watch(input string tag, input int n);
      int bad = 0;
      for (int c = 0; c < n; c++) begin
         @(posedge rxclk); #1;
         if (usb.out_wr !== 1'b0 || chan_rdreq !== 2'b00 || busy !== 1'b0) bad++;
      end
      chk(tag, bad, 0);
   endtask

   // Waits for a packet, collects its beats and compares against the packet rules.
   task automatic run_packet(input int ch, input int ovr, input logic [31:0] rssi_raw,
                             input logic [31:0] ts, input int pulse_ch, input int pulse_beat,
                             input int stop_beat, output int gap);
      logic [15:0] exp_pay [252];
      logic [15:0] got [256];
      logic [31:0] w0;
      int r6, bad, first_bad, wr_miss, busy_miss, foreign, rd_bad;
      bit started, stopped;
      bit own_rd, other_rd;
      for (int i = 0; i < 252; i++) exp_pay[i] = (ch == 0) ? q0[i] : q1[i];
      r6 = (rssi_raw > 32'd63) ? 63 : int'(rssi_raw);
      w0 = (32'(ovr) << 31) + (32'(r6) << 22) + (32'(ch) << 9) + 32'd504;
      gap = 0; started = 0; stopped = 0;
      bad = 0; first_bad = -1; wr_miss = 0; busy_miss = 0; foreign = 0; rd_bad = 0;
      for (int c = 0; c < 64; c++) begin
         @(posedge rxclk); #1;
         if (usb.out_wr === 1'b1) begin
            started = 1;
            break;
         end
         gap++;
      end
      chk($sformatf("pkt_start_ch%0d", ch), 32'(started), 32'd1);
      if (!started) return;
      for (int b = 0; b < 256; b++) begin
         if (b > 0) begin @(posedge rxclk); #1; end
         if (usb.out_wr !== 1'b1) wr_miss++;
         if (busy !== 1'b1) busy_miss++;
         got[b]   = usb.out_data;
         own_rd   = (ch == 0) ? chan_rdreq[0] : chan_rdreq[1];
         other_rd = (ch == 0) ? chan_rdreq[1] : chan_rdreq[0];
         if (other_rd !== 1'b0) foreign++;
         if (own_rd !== ((b >= 3) && (b <= 254))) rd_bad++;
         if (pulse_ch >= 0) chan_overrun = (b == pulse_beat) ? (2'b01 << pulse_ch) : 2'b00;
         if (b == stop_beat) begin
            stopped = 1;
            break;
         end
      end
      chan_overrun = 2'b00;
      chk($sformatf("hdr0_ch%0d", ch), got[0], w0[15:0]);
      chk($sformatf("hdr1_ch%0d", ch), got[1], w0[31:16]);
      chk($sformatf("hdr2_ch%0d", ch), got[2], ts[15:0]);
      chk($sformatf("hdr3_ch%0d", ch), got[3], ts[31:16]);
      chk($sformatf("wr_gaps_ch%0d", ch), wr_miss, 0);
      chk($sformatf("foreign_rdreq_ch%0d", ch), foreign, 0);
      if (stopped) return;
      for (int i = 0; i < 252; i++) begin
         if (got[4+i] !== exp_pay[i]) begin
            if (first_bad < 0) first_bad = i;
            bad++;
         end
      end
      chk($sformatf("payload_ch%0d_first_bad%0d", ch, first_bad), bad, 0);
      chk($sformatf("busy_in_pkt_ch%0d", ch), busy_miss, 0);
      chk($sformatf("rdreq_window_ch%0d", ch), rd_bad, 0);
   endtask

   initial begin
      int gap;
      reset = 1'b0;
      rx_enable = 2'b00;
      chan_overrun = 2'b00;
      rssi = '0;
      timestamp = '0;
      usb.out_have_space = 1'b0;
      chan_usedw = '0;
      chan_fifodata = '0;

      repeat (3) @(posedge rxclk);
      #1;
      chk("rst_out_wr", usb.out_wr, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_pkt_count", pkt_count, 16'd0);
      chk("rst_rdreq", chan_rdreq, 2'b00);
      chk("rst_out_data", usb.out_data, 16'd0);

      // Single channel, known header fields.
      push(0, 300);
      rssi[31:0] = 32'd20;
      timestamp = 32'h12345678;
      rx_enable = 2'b01;
      usb.out_have_space = 1'b1;
      @(posedge rxclk); #1;
      reset = 1'b1;
      run_packet(0, 0, rssi[31:0], timestamp, -1, 0, -1, gap);
      chk("pkt_count_after_first", pkt_count, 16'd1);
      @(posedge rxclk); #1;
      chk("idle_after_first_wr", usb.out_wr, 1'b0);
      @(posedge rxclk); #1;
      chk("idle_after_first_busy", busy, 1'b0);

      // Both channels busy: alternation, back-to-back gap, overrun stickiness, rssi saturation.
      push(0, 1100);
      push(1, 1100);
      rssi[31:0]  = 32'($urandom_range(0, 63));
      rssi[63:32] = 32'h0000_0100;
      timestamp = $urandom;
      rx_enable = 2'b11;
      for (int p = 0; p < 7; p++) begin
         run_packet(seq_ch[p], seq_ovr[p], rssi[32*seq_ch[p] +: 32], timestamp,
                    (seq_pbeat[p] >= 0) ? 1 : -1, seq_pbeat[p], -1, gap);
         if (p > 0) chk($sformatf("gap_pkt%0d", p), gap, 1);
      end
      rx_enable = 2'b00;
      chk("pkt_count_after_alt", pkt_count, 16'd8);
      @(posedge rxclk); #1;
      chk("busy_after_alt", busy, 1'b0);

      // Eligibility thresholds.
      q0.delete();
      q1.delete();
      push(0, 251);
      rx_enable = 2'b01;
      usb.out_have_space = 1'b1;
      idle_watch("idle_usedw_251", 10);
      usb.out_have_space = 1'b0;
      push(0, 49);
      idle_watch("idle_no_space", 10);
      timestamp = $urandom;
      usb.out_have_space = 1'b1;
      run_packet(0, 0, rssi[31:0], timestamp, -1, 0, -1, gap);
      chk("gap_space_raise", gap, 1);
      push(0, 203);
      idle_watch("idle_usedw_251_again", 6);
      push(0, 1);
      run_packet(0, 0, rssi[31:0], timestamp, -1, 0, -1, gap);
      chk("gap_usedw_252", gap, 1);
      chk("pkt_count_after_thresh", pkt_count, 16'd10);

      // Reset mid-payload of a channel-1 packet; pointer and sticky flags must clear.
      push(0, 600);
      push(1, 600);
      rssi[63:32] = 32'($urandom_range(0, 63));
      rx_enable = 2'b11;
      run_packet(1, 0, rssi[63:32], timestamp, 0, 50, 104, gap);
      reset = 1'b0;
      #1;
      chk("abort_out_wr", usb.out_wr, 1'b0);
      chk("abort_rdreq", chan_rdreq, 2'b00);
      chk("abort_busy", busy, 1'b0);
      chk("abort_pkt_count", pkt_count, 16'd0);
      repeat (2) @(posedge rxclk);
      #1;
      reset = 1'b1;
      run_packet(0, 0, rssi[31:0], timestamp, -1, 0, -1, gap);
      rx_enable = 2'b00;
      chk("gap_after_reset", gap, 1);
      chk("pkt_count_after_reset", pkt_count, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
